vector_checker: RTL and testbench

- Synthesizable, parametrised self-checking engine: the on-chip successor of our file-driven controller benches.
- Holds a loadable table of stimulus/expected/care vectors and applies each stimulus to a DUT (e.g. controller, ALU decoder).
- Waits a programmable settle latency, then compares the DUT response under a per-bit care mask and records results.
- Results: error count, first-failure capture and pass/done status. Adds masked compare, stop-on-first-error mode, DUT latency and saturating counters.

---
 rtl/vector_checker.sv | 165 ++++++++++++++++
 tb/tb_vector_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_checker.sv
// vector_checker: on-chip vector table that drives a DUT, waits a settle latency,
// and compares the DUT response under a per-bit care mask.
module vector_checker #(
    parameter int unsigned IN_W   = 13,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LAT    = 0,
    parameter int unsigned ERR_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ld_en,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [IN_W+2*OUT_W-1:0]   ld_data,
    input  logic [ADDR_W:0]           num_vectors,
    input  logic                      start,
    input  logic                      stop_on_err,
    output logic [IN_W-1:0]           dut_in,
    input  logic [OUT_W-1:0]          dut_out,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ERR_W-1:0]          err_count,
    output logic [ADDR_W:0]           vec_count,
    output logic [ADDR_W-1:0]         fail_index,
    output logic [OUT_W-1:0]          fail_got,
    output logic [OUT_W-1:0]          fail_exp
);

    localparam int unsigned VEC_W = IN_W + 2 * OUT_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned LAT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state;
    logic [VEC_W-1:0]  table_mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  num_q;
    logic              stop_q;
    logic [LAT_W-1:0]  wait_cnt;

    logic [VEC_W-1:0]  cur_vec_c;
    logic [IN_W-1:0]   cur_stim_c;
    logic [OUT_W-1:0]  cur_exp_c;
    logic [OUT_W-1:0]  cur_care_c;
    logic              mismatch_c;
    logic              last_c;
    logic [CNT_W-1:0]  num_clamp_c;

    // Combinational table read and masked compare of the current vector
    always_comb begin
        cur_vec_c   = table_mem[idx];
        cur_stim_c  = cur_vec_c[VEC_W-1 -: IN_W];
        cur_exp_c   = cur_vec_c[2*OUT_W-1 -: OUT_W];
        cur_care_c  = cur_vec_c[OUT_W-1:0];
        mismatch_c  = |((dut_out ^ cur_exp_c) & cur_care_c);
        last_c      = (CNT_W'(idx) == (num_q - CNT_W'(1)));
        num_clamp_c = (num_vectors > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_vectors;
    end

    // Vector table: no reset so contents survive a reset; writes blocked during a run
    always_ff @(posedge clk) begin
        if (ld_en && !busy && (32'(ld_addr) < DEPTH)) begin
            table_mem[ld_addr] <= ld_data;
        end
    end

    // Run sequencer: apply, settle, check, record results
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec_count  <= '0;
            fail_index <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
            idx        <= '0;
            num_q      <= '0;
            stop_q     <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end
                    if (start) begin
                        err_count  <= '0;
                        vec_count  <= '0;
                        fail_index <= '0;
                        fail_got   <= '0;
                        fail_exp   <= '0;
                        idx        <= '0;
                        num_q      <= num_clamp_c;
                        stop_q     <= stop_on_err;
                        if (num_clamp_c == '0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_APPLY;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
                S_APPLY: begin
                    dut_in   <= cur_stim_c;
                    wait_cnt <= '0;
                    if (LAT > 0) begin
                        state <= S_WAIT;
                    end else begin
                        state <= S_CHECK;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == LAT_W'(LAT - 1)) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (mismatch_c) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        // saturation never returns to zero, so zero marks "no mismatch yet"
                        if (err_count == '0) begin
                            fail_index <= idx;
                            fail_got   <= dut_out;
                            fail_exp   <= cur_exp_c;
                        end
                    end
                    vec_count <= vec_count + CNT_W'(1);
                    if (last_c || (stop_q && mismatch_c)) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        state <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: two instances (LAT=0/ERR_W=4 and LAT=2/ERR_W=2)
// share the load/start bus; results are checked against a vector-list model.
module tb_vector_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [32:0] ld_data = '0;
    logic [4:0]  num_vectors = '0;
    logic        start = 1'b0;
    logic        stop_on_err = 1'b0;

    logic [12:0] dut_in0, dut_in1;
    logic [9:0]  dut_out0, dut_out1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0]  err0;
    logic [1:0]  err1;
    logic [4:0]  vec0, vec1;
    logic [3:0]  fidx0, fidx1;
    logic [9:0]  fgot0, fgot1, fexp0, fexp1;

    int checks = 0;
    int errors = 0;
    logic [32:0] tbl [16];

    always #5 clk = ~clk;

    // Behavioural stand-in for the device under test
    function automatic logic [9:0] dut_fn(input logic [12:0] x);
        return 10'(x ^ (x >> 4));
    endfunction

    assign dut_out0 = dut_fn(dut_in0);
    assign dut_out1 = dut_fn(dut_in1);

    vector_checker u0 (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .num_vectors(num_vectors), .start(start), .stop_on_err(stop_on_err),
        .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .vec_count(vec0), .fail_index(fidx0), .fail_got(fgot0),
        .fail_exp(fexp0)
    );

    vector_checker #(.LAT(2), .ERR_W(2)) u1 (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .num_vectors(num_vectors), .start(start), .stop_on_err(stop_on_err),
        .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .vec_count(vec1), .fail_index(fidx1), .fail_got(fgot1),
        .fail_exp(fexp1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int a, input logic [32:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 4'(a);
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // errbits flips response bits relative to the DUT function: mismatch iff errbits & care
    task automatic set_vec(input int a, input logic [12:0] stim, input logic [9:0] errbits,
                           input logic [9:0] care);
        logic [32:0] d;
        d = {stim, dut_fn(stim) ^ errbits, care};
        tbl[a] = d;
        load(a, d);
    endtask

    // Walks the vector list as the checker should, returning the expected results
    task automatic model(input int num, input bit stop, input int lat, input int maxerr,
                         output int n_chk, output int e_err, output int e_fidx,
                         output int e_fgot, output int e_fexp, output int e_last,
                         output int e_time, output bit e_pass);
        int n, cnt;
        logic [12:0] s;
        logic [9:0]  ex, cr, g;
        n = (num > 16) ? 16 : num;
        cnt = 0; n_chk = 0; e_fidx = 0; e_fgot = 0; e_fexp = 0; e_last = 0;
        for (int i = 0; i < n; i++) begin
            s  = tbl[i][32:20];
            ex = tbl[i][19:10];
            cr = tbl[i][9:0];
            g  = dut_fn(s);
            n_chk++;
            e_last = int'(s);
            if (((g ^ ex) & cr) != 10'd0) begin
                if (cnt == 0) begin
                    e_fidx = i; e_fgot = int'(g); e_fexp = int'(ex);
                end
                cnt++;
                if (stop) break;
            end
        end
        e_err  = (cnt > maxerr) ? maxerr : cnt;
        e_pass = (cnt == 0);
        e_time = (n_chk == 0) ? 0 : n_chk * (lat + 2) + 1;
    endtask

    task automatic verify(input string tag, input int num, input bit stop, input int lat,
                          input int maxerr, input int t, input logic d, input logic p,
                          input logic b, input int ec, input int vc, input int fi,
                          input int fg, input int fe, input int di);
        int n_chk, e_err, e_fidx, e_fgot, e_fexp, e_last, e_time;
        bit e_pass;
        model(num, stop, lat, maxerr, n_chk, e_err, e_fidx, e_fgot, e_fexp, e_last, e_time, e_pass);
        chk({tag, ".time"}, t, e_time);
        chk({tag, ".done"}, d, 1);
        chk({tag, ".busy"}, b, 0);
        chk({tag, ".pass"}, p, e_pass);
        chk({tag, ".err"}, ec, e_err);
        chk({tag, ".vec"}, vc, n_chk);
        chk({tag, ".fidx"}, fi, e_fidx);
        chk({tag, ".fgot"}, fg, e_fgot);
        chk({tag, ".fexp"}, fe, e_fexp);
        if (n_chk > 0) chk({tag, ".dut_in"}, di, e_last);
    endtask

    task automatic pulse_start(input int num, input bit stop);
        @(negedge clk);
        num_vectors = 5'(num);
        stop_on_err = stop;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input string tag, input int num, input bit stop);
        int t0, t1;
        t0 = -1; t1 = -1;
        pulse_start(num, stop);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done0 && t0 < 0) t0 = cyc;
            if (done1 && t1 < 0) t1 = cyc;
            if (t0 >= 0 && t1 >= 0) break;
            @(posedge clk);
            #1;
        end
        verify({tag, ".u0"}, num, stop, 0, 15, t0, done0, pass0, busy0, int'(err0),
               int'(vec0), int'(fidx0), int'(fgot0), int'(fexp0), int'(dut_in0));
        verify({tag, ".u1"}, num, stop, 2, 3, t1, done1, pass1, busy1, int'(err1),
               int'(vec1), int'(fidx1), int'(fgot1), int'(fexp1), int'(dut_in1));
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            if (!busy0 && !busy1) break;
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", k < 300, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", busy0, 0);
        chk("rst.done", done0, 0);
        chk("rst.pass", pass0, 0);
        chk("rst.err", err0, 0);
        chk("rst.vec", vec0, 0);
        chk("rst.dut_in", dut_in0, 0);
        chk("rst.fail", {fidx0, fgot0, fexp0}, 0);
        chk("rst.u1", {busy1, done1, err1, vec1, dut_in1}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Three matching vectors
        set_vec(0, 13'h0123, 10'h000, 10'h3FF);
        set_vec(1, 13'h1A5C, 10'h000, 10'h3FF);
        set_vec(2, 13'h07E1, 10'h000, 10'h3FF);
        run("all_pass", 3, 1'b0);

        // Vector 1 off by the LSB
        set_vec(1, 13'h1A5C, 10'h001, 10'h3FF);
        run("one_err", 3, 1'b0);

        // Same error masked by care
        set_vec(1, 13'h1A5C, 10'h001, 10'h3FE);
        run("masked", 3, 1'b0);

        // care=0 never fails, whatever the response
        set_vec(2, 13'h07E1, 10'h3FF, 10'h000);
        run("care_zero", 3, 1'b0);

        // Stop on first of two mismatches
        set_vec(1, 13'h1A5C, 10'h010, 10'h3FF);
        set_vec(2, 13'h07E1, 10'h200, 10'h3FF);
        run("stop", 3, 1'b1);
        run("nostop", 3, 1'b0);

        run("zero", 0, 1'b0);

        // Five failures: saturates the 2-bit counter
        for (int i = 0; i < 16; i++) set_vec(i, 13'(i * 37 + 5), (i < 5) ? 10'h004 : 10'h000, 10'h3FF);
        run("sat", 5, 1'b0);
        run("clamp", 31, 1'b0);

        // Reset during vector 2, then re-run from the surviving table
        set_vec(1, 13'h0042, 10'h080, 10'h3FF);
        run("pre_rst", 5, 1'b0);
        pulse_start(5, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("mid.busy_before", busy0, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid.busy", busy0, 0);
        chk("mid.err", err0, 0);
        chk("mid.dut_in", dut_in0, 0);
        chk("mid.done", done0, 0);
        chk("mid.u1", {busy1, err1, dut_in1}, 0);
        @(negedge clk);
        reset = 1'b0;
        run("post_rst", 5, 1'b0);

        // Load attempted while busy must not land
        pulse_start(3, 1'b0);
        load(0, {13'h1FFF, 10'h155, 10'h3FF});
        wait_idle();
        run("ld_guard", 3, 1'b0);

        // Randomized tables and run settings
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 16; i++) begin
                set_vec(i, 13'($urandom),
                        ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'h000,
                        ($urandom_range(0, 1) == 0) ? 10'h3FF : 10'($urandom));
            end
            run("rand", int'($urandom_range(0, 18)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
